// File: rtl/load_store_unit.sv
// load_store_unit: sequences RV32I loads/stores onto a single-port word memory.
// Byte/halfword stores are done as read-modify-write (READ then WRITE).
// Optional feature macro: LSU_MISALIGN_TRAP_EN (flag misaligned halfword/word accesses).
module load_store_unit #(
    parameter int unsigned MEM_WORDS = 100
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    output logic [31:0] AddrB,
    output logic [31:0] DataWrite,
    output logic        MemRW,
    input  logic [31:0] DataB
);
    localparam int unsigned DW = 32;
    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LOAD  = 3'd1,
        READ  = 3'd2,
        WRITE = 3'd3,
        RESP  = 3'd4
    } state_t;

    state_t          state, state_next;
    logic            we_q;
    logic [2:0]      funct3_q;
    logic [1:0]      addr_lo_q;
    logic [DW-1:0]   wdata_q;
    logic [DW-1:0]   addr_b_next, data_write_next, rsp_rdata_next, load_result_c;
    logic            rsp_err_next, accept_c;
    logic            funct3_ok_c, range_err_c, misalign_c, req_err_c;

    // Select and extend the addressed byte/halfword of a memory word.
    function automatic logic [31:0] load_extend(input logic [2:0] f3, input logic [1:0] off,
                                                input logic [31:0] word);
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] r;
        b = 8'(word >> {off, 3'b000});
        h = 16'(word >> {off[1], 4'b0000});
        case (f3)
            F3_B:    r = {{24{b[7]}}, b};
            F3_H:    r = {{16{h[15]}}, h};
            F3_W:    r = word;
            F3_BU:   r = {24'h0, b};
            F3_HU:   r = {16'h0, h};
            default: r = 32'h0;
        endcase
        return r;
    endfunction

    // Replace the addressed byte/halfword of the old word with store data.
    function automatic logic [31:0] store_merge(input logic [2:0] f3, input logic [1:0] off,
                                                input logic [31:0] old, input logic [31:0] wdata);
        logic [4:0]  sh;
        logic [31:0] mask, r;
        sh   = 5'd0;
        mask = 32'h0;
        r    = wdata;
        case (f3)
            F3_B: begin
                sh   = {off, 3'b000};
                mask = 32'h0000_00FF << sh;
                r    = (old & ~mask) | ((wdata & 32'h0000_00FF) << sh);
            end
            F3_H: begin
                sh   = {off[1], 4'b0000};
                mask = 32'h0000_FFFF << sh;
                r    = (old & ~mask) | ((wdata & 32'h0000_FFFF) << sh);
            end
            default: r = wdata;
        endcase
        return r;
    endfunction

    // Request legality: width code, word range and (optionally) alignment.
    assign funct3_ok_c = req_we ? (req_funct3 inside {F3_B, F3_H, F3_W})
                                : (req_funct3 inside {F3_B, F3_H, F3_W, F3_BU, F3_HU});
    assign range_err_c = {2'b00, req_addr[31:2]} >= MEM_WORDS;
`ifdef LSU_MISALIGN_TRAP_EN
    assign misalign_c  = ((req_funct3[1:0] == 2'b01) && req_addr[0]) ||
                         ((req_funct3[1:0] == 2'b10) && (req_addr[1:0] != 2'b00));
`else
    assign misalign_c  = 1'b0;
`endif
    assign req_err_c   = !funct3_ok_c || range_err_c || misalign_c;

    // Load result for the latched request; stores respond with zero data.
    assign load_result_c = we_q ? 32'h0 : load_extend(funct3_q, addr_lo_q, DataB);

    // Next state and next values of the registered outputs.
    always_comb begin
        state_next      = state;
        addr_b_next     = AddrB;
        data_write_next = DataWrite;
        rsp_rdata_next  = rsp_rdata;
        rsp_err_next    = rsp_err;
        accept_c        = 1'b0;
        case (state)
            IDLE: begin
                if (req_valid) begin
                    accept_c = 1'b1;
                    if (req_err_c) begin
                        state_next     = RESP;
                        rsp_err_next   = 1'b1;
                        rsp_rdata_next = 32'h0;
                    end else begin
                        rsp_err_next = 1'b0;
                        addr_b_next  = {2'b00, req_addr[31:2]};
                        if (!req_we) begin
                            state_next = LOAD;
                        end else if (req_funct3 == F3_W) begin
                            state_next      = WRITE;
                            data_write_next = req_wdata;
                        end else begin
                            state_next = READ;
                        end
                    end
                end
            end
            LOAD: begin
                rsp_rdata_next = load_result_c;
                state_next     = RESP;
            end
            READ: begin
                data_write_next = store_merge(funct3_q, addr_lo_q, DataB, wdata_q);
                state_next      = WRITE;
            end
            WRITE: begin
                rsp_rdata_next = load_result_c;
                state_next     = RESP;
            end
            RESP: begin
                rsp_err_next = 1'b0;
                state_next   = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // State, registered outputs and latched request fields.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            req_ready <= 1'b1;
            rsp_valid <= 1'b0;
            rsp_err   <= 1'b0;
            rsp_rdata <= 32'h0;
            MemRW     <= 1'b0;
            AddrB     <= 32'h0;
            DataWrite <= 32'h0;
            we_q      <= 1'b0;
            funct3_q  <= 3'b000;
            addr_lo_q <= 2'b00;
            wdata_q   <= 32'h0;
        end else begin
            state     <= state_next;
            req_ready <= (state_next == IDLE);
            rsp_valid <= (state_next == RESP);
            MemRW     <= (state_next == WRITE);
            rsp_err   <= rsp_err_next;
            rsp_rdata <= rsp_rdata_next;
            AddrB     <= addr_b_next;
            DataWrite <= data_write_next;
            if (accept_c) begin
                we_q      <= req_we;
                funct3_q  <= req_funct3;
                addr_lo_q <= req_addr[1:0];
                wdata_q   <= req_wdata;
            end
        end
    end
endmodule

// File: tb/tb_load_store_unit.sv
// tb_load_store_unit: directed + randomized accesses against a word-array reference model.
// Honors LSU_MISALIGN_TRAP_EN the same way as the design.
module tb_load_store_unit;
    localparam int unsigned MEM_WORDS = 100;

    logic        clk, rst_n;
    logic        req_valid, req_ready, req_we;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr, req_wdata;
    logic        rsp_valid, rsp_err, mem_rw;
    logic [31:0] rsp_rdata, addr_b, data_write, data_b;

    logic [31:0] mem     [MEM_WORDS];
    logic [31:0] ref_mem [MEM_WORDS];
    int n_pass, n_checks;

    load_store_unit #(.MEM_WORDS(MEM_WORDS)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .AddrB(addr_b), .DataWrite(data_write), .MemRW(mem_rw), .DataB(data_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Downstream memory: combinational read, write on rising edge when MemRW=1.
    assign data_b = (addr_b < MEM_WORDS) ? mem[addr_b] : 32'h0;
    always @(posedge clk) if (mem_rw && addr_b < MEM_WORDS) mem[addr_b] = data_write;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    function automatic logic model_err(input logic we, input logic [2:0] f3, input logic [31:0] addr);
        logic legal;
        legal = we ? (f3 inside {3'd0, 3'd1, 3'd2}) : (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
`ifdef LSU_MISALIGN_TRAP_EN
        if ((f3 == 3'd1 || f3 == 3'd5) && addr[0]) legal = 1'b0;
        if (f3 == 3'd2 && addr[1:0] != 2'b00) legal = 1'b0;
`endif
        return !legal || ((addr >> 2) >= MEM_WORDS);
    endfunction

    function automatic logic [31:0] model_load(input logic [2:0] f3, input logic [1:0] off,
                                               input logic [31:0] word);
        int unsigned b, h;
        b = (word >> (8 * int'(off))) & 32'hFF;
        h = (word >> (16 * int'(off[1]))) & 32'hFFFF;
        case (f3)
            3'd0: return (b >= 128) ? b + 32'hFFFF_FF00 : b;
            3'd1: return (h >= 32768) ? h + 32'hFFFF_0000 : h;
            3'd2: return word;
            3'd4: return b;
            3'd5: return h;
            default: return 32'h0;
        endcase
    endfunction

    function automatic logic [31:0] model_store(input logic [2:0] f3, input logic [1:0] off,
                                                input logic [31:0] old, input logic [31:0] wd);
        logic [7:0] by [4];
        for (int i = 0; i < 4; i++) by[i] = old[8*i +: 8];
        if (f3 == 3'd2) return wd;
        if (f3 == 3'd0) by[off] = wd[7:0];
        else begin
            by[{off[1], 1'b0}] = wd[7:0];
            by[{off[1], 1'b1}] = wd[15:8];
        end
        return {by[3], by[2], by[1], by[0]};
    endfunction

    task automatic preload(input int idx, input logic [31:0] val);
        mem[idx]     = val;
        ref_mem[idx] = val;
    endtask

    // Issue one request from an IDLE negedge and check it against the model.
    task automatic do_access(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                             input logic [31:0] wd, output logic [31:0] rdata, output logic err,
                             output int lat, output logic [31:0] dw);
        logic        exp_err, seen, writes;
        logic [31:0] idx, old, exp_rd, nw;
        int          exp_lat, wr_cnt;
        idx     = addr >> 2;
        exp_err = model_err(we, f3, addr);
        old     = exp_err ? 32'h0 : ref_mem[idx];
        writes  = we && !exp_err;
        exp_rd  = (exp_err || we) ? 32'h0 : model_load(f3, addr[1:0], old);
        nw      = writes ? model_store(f3, addr[1:0], old, wd) : 32'h0;
        exp_lat = exp_err ? 1 : (!we ? 2 : (f3 == 3'd2 ? 2 : 3));

        check("ready_before", 32'(req_ready), 32'd1);
        req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wd;
        @(posedge clk); #1;
        seen = 1'b0; lat = 0; wr_cnt = 0; dw = 32'h0; rdata = 32'h0; err = 1'b0;
        for (int c = 1; c <= 8 && !seen; c++) begin
            req_valid = 1'($urandom); req_we = 1'($urandom); req_funct3 = 3'($urandom);
            req_addr = $urandom; req_wdata = $urandom;
            @(negedge clk);
            if (c == 1) check("busy", 32'(req_ready), 32'd0);
            if (mem_rw) begin
                wr_cnt++;
                check("addr_b", addr_b, idx);
                dw = data_write;
            end
            if (rsp_valid) begin
                seen = 1'b1; lat = c; rdata = rsp_rdata; err = rsp_err;
                req_valid = 1'b0;
            end
        end
        req_valid = 1'b0;
        if (!seen) check("rsp_timeout", 32'd0, 32'd1);
        check("latency", 32'(lat), 32'(exp_lat));
        check("rsp_err", 32'(err), 32'(exp_err));
        check("rsp_rdata", rdata, exp_rd);
        check("write_cycles", 32'(wr_cnt), writes ? 32'd1 : 32'd0);
        if (writes) check("data_write", dw, nw);
        @(negedge clk);
        check("rsp_pulse", 32'(rsp_valid), 32'd0);
        check("ready_after", 32'(req_ready), 32'd1);
        if (writes) begin
            ref_mem[idx] = nw;
            check("mem_word", mem[idx], nw);
        end
    endtask

    initial begin
        logic [31:0] rd, dw, a, w;
        logic        er, we;
        logic [2:0]  f3;
        int          lt, idx;
        n_pass = 0; n_checks = 0;
        rst_n = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_funct3 = 3'b000;
        req_addr = 32'h0; req_wdata = 32'h0;
        for (int i = 0; i < int'(MEM_WORDS); i++) preload(i, $urandom);
        @(negedge clk); @(negedge clk);
        check("rst_ready", 32'(req_ready), 32'd1);
        check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst_rsp_err", 32'(rsp_err), 32'd0);
        check("rst_rsp_rdata", rsp_rdata, 32'h0);
        check("rst_memrw", 32'(mem_rw), 32'd0);
        check("rst_addr_b", addr_b, 32'h0);
        check("rst_data_write", data_write, 32'h0);
        rst_n = 1'b1;
        @(negedge clk);

        // SW then LW of the same word
        do_access(1'b1, 3'd2, 32'h8, 32'hDEAD_BEEF, rd, er, lt, dw);
        do_access(1'b0, 3'd2, 32'h8, 32'h0, rd, er, lt, dw);
        check("lw_deadbeef", rd, 32'hDEAD_BEEF);
        // SB read-modify-write
        preload(2, 32'h1122_3344);
        do_access(1'b1, 3'd0, 32'h9, 32'h0000_00AA, rd, er, lt, dw);
        check("sb_merge", dw, 32'h1122_AA44);
        check("sb_latency", 32'(lt), 32'd3);
        // LB / LBU sign and zero extension
        preload(2, 32'h1122_F044);
        do_access(1'b0, 3'd0, 32'h9, 32'h0, rd, er, lt, dw);
        check("lb_sext", rd, 32'hFFFF_FFF0);
        do_access(1'b0, 3'd4, 32'h9, 32'h0, rd, er, lt, dw);
        check("lbu_zext", rd, 32'h0000_00F0);
        // Out-of-range store and illegal load width
        do_access(1'b1, 3'd2, 32'h190, 32'h1234_5678, rd, er, lt, dw);
        check("range_err", 32'(er), 32'd1);
        do_access(1'b0, 3'd3, 32'h4, 32'h0, rd, er, lt, dw);
        check("illegal_f3_err", 32'(er), 32'd1);
        // Halfword at addr 0x3
        preload(0, 32'h8001_1234);
        do_access(1'b0, 3'd1, 32'h3, 32'h0, rd, er, lt, dw);
`ifdef LSU_MISALIGN_TRAP_EN
        check("lh_misalign_err", 32'(er), 32'd1);
`else
        check("lh_misalign_ignored", rd, 32'hFFFF_8001);
`endif
        // Reset during WRITE of SW
        preload(5, 32'h0123_4567);
        check("ready_before_rst", 32'(req_ready), 32'd1);
        req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'd2;
        req_addr = 32'h14; req_wdata = 32'hCAFE_F00D;
        @(posedge clk); #1 req_valid = 1'b0;
        @(negedge clk);
        check("write_active", 32'(mem_rw), 32'd1);
        #1 rst_n = 1'b0;
        #1;
        check("rst_memrw_async", 32'(mem_rw), 32'd0);
        check("rst_ready_async", 32'(req_ready), 32'd1);
        @(negedge clk);
        check("rst_no_write", mem[5], 32'h0123_4567);
        check("rst_no_rsp", 32'(rsp_valid), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        check("ready_after_rst", 32'(req_ready), 32'd1);
        check("no_rsp_after_rst", 32'(rsp_valid), 32'd0);
        do_access(1'b0, 3'd2, 32'h14, 32'h0, rd, er, lt, dw);
        check("word_unchanged", rd, 32'h0123_4567);

        // Randomized mix of loads and stores
        for (int n = 0; n < 250; n++) begin
            we  = 1'($urandom);
            idx = int'($urandom_range(0, MEM_WORDS + 2));
            a   = {30'(idx), 2'($urandom)};
            if ($urandom_range(0, 15) == 0) a = $urandom;
            if ($urandom_range(0, 4) == 0) f3 = 3'($urandom);
            else if (we) f3 = 3'($urandom_range(0, 2));
            else begin
                w  = 32'($urandom_range(0, 4));
                f3 = (w > 32'd2) ? 3'(w + 32'd1) : 3'(w);
            end
            do_access(we, f3, a, $urandom, rd, er, lt, dw);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 SHALL have parameter MEM_WORDS, default 100: number of 32-bit words in the downstream data memory; valid word indices are 0..MEM_WORDS-1.
REQ-002 SHALL have port clk, input, 1: single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_n, input, 1: asynchronous, active-low reset.
REQ-004 SHALL have port req_valid, input, 1: access request present.
REQ-005 SHALL have port req_ready, output, 1: unit accepts a request this cycle.
REQ-006 SHALL have port req_we, input, 1: 1 = store, 0 = load.
REQ-007 SHALL have port req_funct3, input, 3: RV32I width code; loads 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU; stores 000 SB, 001 SH, 010 SW.
REQ-008 SHALL have port req_addr, input, 32: byte address.
REQ-009 SHALL have port req_wdata, input, 32: store data, right-aligned.
REQ-010 SHALL have port rsp_valid, output, 1: one-cycle completion pulse.
REQ-011 SHALL have port rsp_rdata, output, 32: extended load result; 0 for stores and errors.
REQ-012 SHALL have port rsp_err, output, 1: qualified by rsp_valid; illegal, out-of-range or misaligned access.
REQ-013 SHALL have port AddrB, output, 32: memory word index, {2'b00, addr[31:2]}.
REQ-014 SHALL have port DataWrite, output, 32: word written to memory.
REQ-015 SHALL have port MemRW, output, 1: 1 = memory writes DataWrite at the next rising edge; 0 = memory presents word combinationally on DataB.
REQ-016 SHALL have port DataB, input, 32: memory read data, valid while MemRW=0.

Function
REQ-017 SHALL implement FSM states IDLE, LOAD, READ, WRITE, RESP; req_ready=1 only in IDLE.
REQ-018 SHALL latch req_we, req_funct3, req_addr and req_wdata on acceptance (req_valid and req_ready at a rising edge).
REQ-019 SHALL transition from IDLE on acceptance: load to LOAD; SW to WRITE; SB/SH to READ; error request to RESP with no memory access.
REQ-020 SHALL, in LOAD, drive MemRW=0, capture DataB at the next edge, and go to RESP; rsp_valid occurs 2 cycles after acceptance.
REQ-021 SHALL, in READ, drive MemRW=0, capture DataB as the old word, and go to WRITE.
REQ-022 SHALL, in WRITE, drive MemRW=1 for exactly one cycle and go to RESP; DataWrite is the SW data, or the old word with only the addressed byte (addr[1:0]) or halfword (addr[1]) replaced.
REQ-023 SHALL pulse rsp_valid in RESP for one cycle and return to IDLE; a new request can be accepted on the cycle after RESP.
REQ-024 SHALL select the load byte by addr[1:0] and the halfword by addr[1]; LB/LH sign-extend, LBU/LHU zero-extend, and LW passes the word unchanged.
REQ-025 SHALL flag error for funct3 values not listed in REQ-007 and for word index >= MEM_WORDS; for any error, rsp_err=1, rsp_rdata=0 and MemRW is never 1.
REQ-026 SHALL drive MemRW=0 in every state except WRITE; AddrB and DataWrite hold their last values outside an access.
REQ-027 SHALL ignore req_valid outside IDLE; there is no response backpressure.

Reset
REQ-028 SHALL, while rst_n=0, force state IDLE, req_ready=1, rsp_valid=0, rsp_err=0, rsp_rdata=0, MemRW=0, AddrB=0, DataWrite=0, and clear all latched request fields.
REQ-029 SHALL abandon any in-flight access on reset assertion, with no memory write and no response; an access in WRITE is aborted because MemRW drops asynchronously.

Configuration
REQ-030 SHALL, with macro LSU_MISALIGN_TRAP_EN defined, treat halfword accesses with addr[0]=1 and word accesses with addr[1:0]!=0 as errors per REQ-025.
REQ-031 SHALL, without LSU_MISALIGN_TRAP_EN, silently ignore misaligned low address bits (halfword: addr[0] ignored; word: addr[1:0] ignored) and never flag misalignment.

Verification
REQ-032 SHALL cover SW addr 0x8, data 0xDEADBEEF, then LW 0x8 -> MemRW=1 one cycle with AddrB=2; LW rsp_rdata=0xDEADBEEF 2 cycles after acceptance.
REQ-033 SHALL cover SB addr 0x9, data 0x000000AA over a word holding 0x11223344 -> READ then WRITE; DataWrite=0x1122AA44; rsp_valid 3 cycles after acceptance.
REQ-034 SHALL cover LB and LBU at addr 0x9 with word 0x1122F044 -> LB rsp_rdata=0xFFFFFFF0; LBU rsp_rdata=0x000000F0.
REQ-035 SHALL cover SW to word index 100 (addr 0x190) with MEM_WORDS=100, and illegal load funct3 011 -> rsp_err=1, rsp_rdata=0, MemRW stays 0, response 1 cycle after acceptance.
REQ-036 SHALL cover LH at addr 0x3 -> with LSU_MISALIGN_TRAP_EN, rsp_err=1; without it, halfword at addr 0x2 returned, rsp_err=0.
REQ-037 SHALL cover rst_n asserted during WRITE of SW -> MemRW=0 immediately, memory word unchanged, no rsp_valid, req_ready=1 after reset.
